// File: rtl/sevenseg_pkg.sv
// Shared constants and types for the seven-segment scan controller.
package sevenseg_pkg;
  localparam logic [3:0] BCD_BLANK          = 4'hF;
  localparam logic       ANODE_OFF          = 1'b1;
  localparam logic       ANODE_ON           = 1'b0;
  localparam int         DEFAULT_NUM_DIGITS = 4;

  typedef logic [3:0] digit_t;
endpackage

// File: rtl/scan_prescaler.sv
// Refresh prescaler: produces the per-digit slot tick and the anti-ghost blank window.
module scan_prescaler #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic slot_tick,
  output logic in_blank
);
  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK = CNT_W'(BLANK_CYC);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: wrap at end of slot, park at zero while disabled so re-enable gets a full blank.
  always_comb begin
    cnt_d = '0;
    if (enable && cnt_q != LAST) cnt_d = cnt_q + 1'b1;
  end

  // Refresh count register.
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign slot_tick = enable && (cnt_q == LAST);
  assign in_blank  = (cnt_q < BLANK);
endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Multi-digit common-anode scan controller with tear-free frame commit and
// leading-zero blanking; outputs are registered one cycle after count/index.
module sevenseg_scan_ctrl
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS  = DEFAULT_NUM_DIGITS,
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  output logic [3:0]              bcd_out,
  output logic [NUM_DIGITS-1:0]   anode_n,
  output logic                    dp_n
);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic slot_tick, in_blank;

  scan_prescaler #(
    .REFRESH_DIV (REFRESH_DIV),
    .BLANK_CYC   (BLANK_CYC)
  ) u_presc (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .slot_tick (slot_tick),
    .in_blank  (in_blank)
  );

  logic [4*NUM_DIGITS-1:0] act_dig_q, pend_dig_q;
  logic [NUM_DIGITS-1:0]   act_dp_q, pend_dp_q;
  logic                    pend_vld_q;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    frame_end;

  assign frame_end = slot_tick && (idx_q == IDX_LAST);

  // Frame buffers: loads land in pending, and only reach the active frame at a frame boundary.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      act_dig_q  <= '0;
      act_dp_q   <= '0;
      pend_dig_q <= '0;
      pend_dp_q  <= '0;
      pend_vld_q <= 1'b0;
    end else if (frame_end) begin
      if (load) begin
        act_dig_q <= digits_in;
        act_dp_q  <= dp_in;
      end else if (pend_vld_q) begin
        act_dig_q <= pend_dig_q;
        act_dp_q  <= pend_dp_q;
      end
      pend_vld_q <= 1'b0;
    end else if (load) begin
      pend_dig_q <= digits_in;
      pend_dp_q  <= dp_in;
      pend_vld_q <= 1'b1;
    end
  end

  // Next digit index on each slot tick.
  always_comb begin
    idx_d = idx_q;
    if (slot_tick) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
  end

  // Digit index register.
  always_ff @(posedge clk) begin
    if (!rst_n) idx_q <= '0;
    else        idx_q <= idx_d;
  end

  logic [NUM_DIGITS-1:0] supp;
  logic                  all_zero;

  // Leading-zero mask: digit i is suppressed when it and every digit above it are zero; digit 0 never.
  always_comb begin
    supp     = '0;
    all_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      all_zero = all_zero & (act_dig_q[4*i +: 4] == 4'h0);
      supp[i]  = blank_lz & all_zero;
    end
  end

  digit_t                cur_dig;
  logic                  cur_dp, cur_supp;
  logic [NUM_DIGITS-1:0] anode_d;

  // Select the current digit and build the one-cold anode pattern.
  always_comb begin
    cur_dig  = '0;
    cur_dp   = 1'b0;
    cur_supp = 1'b0;
    anode_d  = {NUM_DIGITS{ANODE_OFF}};
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_dig    = act_dig_q[4*i +: 4];
        cur_dp     = act_dp_q[i];
        cur_supp   = supp[i];
        anode_d[i] = ANODE_ON;
      end
    end
  end

  logic [3:0]            bcd_q;
  logic [NUM_DIGITS-1:0] anode_q;
  logic                  dp_n_q;

  // Registered display outputs; dark during reset, disable and the blank window.
  always_ff @(posedge clk) begin
    if (!rst_n || !enable || in_blank) begin
      bcd_q   <= BCD_BLANK;
      anode_q <= {NUM_DIGITS{ANODE_OFF}};
      dp_n_q  <= 1'b1;
    end else begin
      bcd_q   <= cur_supp ? BCD_BLANK : cur_dig;
      anode_q <= anode_d;
      dp_n_q  <= ~cur_dp;
    end
  end

  assign bcd_out = bcd_q;
  assign anode_n = anode_q;
  assign dp_n    = dp_n_q;
endmodule
